// File: rtl/estu_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : estu_result_fifo
// Description : Captures ESTU last-layer results, each tagged with its
//               timestep, into a FIFO. The FIFO is presented to the servant
//               CPU as a Wishbone slave with status, drop counting and a
//               result-available interrupt.
// Ports       : i_clk, i_rst_n      - clock, async active-low reset
//               i_valid/i_data/
//               i_timestep          - ESTU result stream (level valid)
//               i_wb_*              - Wishbone slave request (2-bit word addr)
//               o_wb_rdt/o_wb_ack   - Wishbone read data / 1-cycle ack
//               o_irq               - irq_en & fifo not empty (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module estu_result_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 13,
  parameter int TS_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TS_W-1:0]   i_timestep,
  input  logic [1:0]        i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic              i_wb_we,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  output logic [31:0]       o_wb_rdt,
  output logic              o_wb_ack,
  output logic              o_irq
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = TS_W + DATA_W;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_DROP   = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               valid_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               irq_en_q, irq_en_d;
  logic               ack_q;
  logic [31:0]        rdt_q, rdt_d;
  logic               irq_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic w_empty, w_full;
  logic w_req, w_rd_data, w_pop;
  logic w_flush, w_ctrl_wr, w_drop_clr;
  logic w_push_req, w_push, w_drop;
  logic w_unused_dat;

  // Only CTRL bits [1:0] carry meaning on writes.
  assign w_unused_dat = &{1'b0, i_wb_dat[31:2]};

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == CW'(DEPTH));

  // A request is only seen once; the ack cycle masks the still-held strobe.
  assign w_req      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign w_rd_data  = w_req & ~i_wb_we & (i_wb_adr == ADR_DATA);
  assign w_pop      = w_rd_data & ~w_empty;
  assign w_ctrl_wr  = w_req & i_wb_we & (i_wb_adr == ADR_CTRL);
  assign w_flush    = w_ctrl_wr & i_wb_dat[1];
  assign w_drop_clr = w_req & i_wb_we & (i_wb_adr == ADR_DROP);

  // One entry per rising edge of the level valid. A same-cycle pop frees a
  // slot so a full FIFO can still accept; flush discards silently.
  assign w_push_req = i_valid & ~valid_q;
  assign w_push     = w_push_req & ~w_flush & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_flush & w_full & ~w_pop;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    irq_en_d   = irq_en_q;
    rdt_d      = 32'h0;

    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (w_drop) ovf_d = 1'b1;
    end

    if (w_ctrl_wr) irq_en_d = i_wb_dat[0];

    // Clear takes priority over a drop in the same cycle.
    if (w_drop_clr) begin
      drop_cnt_d = 16'h0;
    end else if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'h1;
    end

    // Read data is returned only for reads; write acks carry zero.
    if (w_req && !i_wb_we) begin
      case (i_wb_adr)
        ADR_DATA:   rdt_d = w_empty ? 32'h0 : {1'b1, 31'(mem_q[rd_ptr_q])};
        ADR_STATUS: rdt_d = {19'b0, 5'(count_q), 5'b0, ovf_q, w_full, w_empty};
        ADR_CTRL:   rdt_d = {30'b0, 1'b0, irq_en_q};
        default:    rdt_d = {16'b0, drop_cnt_q};
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 16'h0;
      irq_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      rdt_q      <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      valid_q    <= i_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      irq_en_q   <= irq_en_d;
      ack_q      <= w_req;
      rdt_q      <= rdt_d;
      // Follows the registered count, so it lags the capture by one cycle.
      irq_q      <= irq_en_q & ~w_empty;
    end
  end

  // Storage array carries no reset; pointers and count define validity.
  // When full, push and pop share an address: the read above sees the old
  // head before this write lands.
  always_ff @(posedge i_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {i_timestep, i_data};
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_irq    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_estu_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_estu_result_fifo
// Description : Directed self-checking bench for estu_result_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_estu_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [12:0] data = '0;
  logic [7:0]  ts = '0;
  logic [1:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  estu_result_fifo #(.DEPTH(16), .DATA_W(13), .TS_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_data     (data),
    .i_timestep (ts),
    .i_wb_adr   (wb_adr),
    .i_wb_dat   (wb_dat),
    .i_wb_we    (wb_we),
    .i_wb_cyc   (wb_cyc),
    .i_wb_stb   (wb_stb),
    .o_wb_rdt   (wb_rdt),
    .o_wb_ack   (wb_ack),
    .o_irq      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wb_read(input logic [1:0] adr, input string tag, output logic [31:0] d);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
    @(posedge clk); #1;
    chk({tag, "_ack"}, {31'b0, wb_ack}, 32'h1);
    d = wb_rdt;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] adr, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, tag, d);
    chk(tag, d, exp);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] v);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat = v;
    @(posedge clk); #1;
    chk("wr_ack", {31'b0, wb_ack}, 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic pulse(input logic [12:0] d, input logic [7:0] t);
    @(posedge clk); #1;
    valid = 1'b1; data = d; ts = t;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  function automatic logic [31:0] word(input logic [7:0] t, input logic [12:0] d);
    return 32'h8000_0000 | ({24'b0, t} << 13) | {19'b0, d};
  endfunction

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdt", wb_rdt, 32'h0);
    chk("rst_ack", {31'b0, wb_ack}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    rd_chk(2'd1, "rst_status", 32'h0000_0001);
    rd_chk(2'd3, "rst_drop", 32'h0);
    rd_chk(2'd2, "rst_ctrl", 32'h0);

    // ---------------- single pulse ----------------
    pulse(13'h1ABC, 8'd5);
    rd_chk(2'd1, "one_status", 32'h0000_0100);
    rd_chk(2'd0, "one_data", 32'h8000_BABC);
    rd_chk(2'd1, "one_status_empty", 32'h0000_0001);

    // ---------------- held valid -> one entry ----------------
    @(posedge clk); #1;
    valid = 1'b1; data = 13'h0123; ts = 8'h22;
    repeat (20) @(posedge clk);
    #1 valid = 1'b0;
    rd_chk(2'd1, "hold_status", 32'h0000_0100);
    rd_chk(2'd0, "hold_data", word(8'h22, 13'h0123));
    rd_chk(2'd1, "hold_status2", 32'h0000_0001);

    // ---------------- overflow: 18 pulses ----------------
    for (int i = 0; i < 18; i++) pulse(13'(13'h100 + i), 8'(i));
    rd_chk(2'd1, "ovf_status", 32'h0000_1006);
    rd_chk(2'd3, "ovf_drop", 32'h2);
    for (int i = 0; i < 16; i++) rd_chk(2'd0, $sformatf("ovf_data%0d", i), word(8'(i), 13'(13'h100 + i)));
    rd_chk(2'd0, "ovf_data_empty", 32'h0);
    rd_chk(2'd1, "ovf_status_after", 32'h0000_0005);
    wb_write(2'd2, 32'h2);
    rd_chk(2'd1, "flush_status", 32'h0000_0001);
    rd_chk(2'd2, "flush_ctrl", 32'h0);
    rd_chk(2'd3, "drop_kept", 32'h2);
    wb_write(2'd3, 32'h0);
    rd_chk(2'd3, "drop_cleared", 32'h0);

    // ---------------- full with simultaneous push + pop ----------------
    for (int i = 0; i < 16; i++) pulse(13'(13'h0A00 + i), 8'(8'h40 + i));
    rd_chk(2'd1, "full_status", 32'h0000_1002);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd0;
    valid = 1'b1; data = 13'h1FFF; ts = 8'hFF;
    @(posedge clk); #1;
    chk("pp_ack", {31'b0, wb_ack}, 32'h1);
    chk("pp_data", wb_rdt, word(8'h40, 13'h0A00));
    wb_cyc = 1'b0; wb_stb = 1'b0; valid = 1'b0;
    rd_chk(2'd1, "pp_status", 32'h0000_1002);
    rd_chk(2'd3, "pp_drop", 32'h0);
    for (int i = 1; i < 16; i++) rd_chk(2'd0, $sformatf("pp_data%0d", i), word(8'(8'h40 + i), 13'(13'h0A00 + i)));
    rd_chk(2'd0, "pp_data_new", 32'h801F_FFFF);
    rd_chk(2'd1, "pp_status_empty", 32'h0000_0001);

    // ---------------- interrupt ----------------
    wb_write(2'd2, 32'h1);
    @(posedge clk); #1;
    valid = 1'b1; data = 13'h0055; ts = 8'h01;
    @(posedge clk); #1;
    chk("irq_push_edge", {31'b0, irq}, 32'h0);
    valid = 1'b0;
    @(posedge clk); #1;
    chk("irq_rise", {31'b0, irq}, 32'h1);
    rd_chk(2'd0, "irq_data", word(8'h01, 13'h0055));
    @(posedge clk); #1;
    chk("irq_fall", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) pulse(13'(i), 8'(i));
    @(posedge clk); #1;
    chk("irq_three", {31'b0, irq}, 32'h1);
    wb_write(2'd2, 32'h3);
    @(posedge clk); #1;
    chk("irq_flush", {31'b0, irq}, 32'h0);
    rd_chk(2'd1, "flush3_status", 32'h0000_0001);
    rd_chk(2'd2, "flush3_ctrl", 32'h1);

    // ---------------- flush and push in the same cycle ----------------
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 2'd2; wb_dat = 32'h3;
    valid = 1'b1; data = 13'h0777; ts = 8'h07;
    @(posedge clk); #1;
    chk("fp_ack", {31'b0, wb_ack}, 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; valid = 1'b0;
    rd_chk(2'd1, "fp_status", 32'h0000_0001);
    rd_chk(2'd3, "fp_drop", 32'h0);

    // ---------------- empty read and ignored DATA write ----------------
    rd_chk(2'd0, "empty_read", 32'h0);
    pulse(13'h0ABC, 8'h0C);
    wb_write(2'd0, 32'hFFFF_FFFF);
    rd_chk(2'd1, "data_wr_ignored", 32'h0000_0100);

    // ---------------- reset during a pending request ----------------
    @(posedge clk); #1;
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack", {31'b0, wb_ack}, 32'h0);
    chk("mid_rst_rdt", wb_rdt, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst_n = 1'b1;
    rd_chk(2'd1, "post_rst_status", 32'h0000_0001);
    rd_chk(2'd2, "post_rst_ctrl", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/estu_result_fifo.md
# estu_result_fifo

Buffers last-layer outputs of the ESTU accelerator so the servant CPU can read them over Wishbone at its own pace. Sits directly downstream of `inst_estu`: it samples the `valid_last_layer` / `data_last_layer` pair and the current `timestep`, stores each result with its timestep tag in a FIFO, and exposes that FIFO as a Wishbone slave with status, drop counting and an interrupt.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 2.
- `DATA_W`, 13: last-layer data width.
- `TS_W`, 8: timestep tag width.

Ports:
- `i_clk` in 1: single clock, same as `wb_clk`.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: ESTU `valid_last_layer`, level signal.
- `i_data` in `DATA_W`: ESTU `data_last_layer`.
- `i_timestep` in `TS_W`: ESTU `timestep`.
- `i_wb_adr` in 2: word address, taken from CPU address bits [3:2].
- `i_wb_dat` in 32: write data.
- `i_wb_we` in 1: write enable.
- `i_wb_cyc` in 1: Wishbone cycle.
- `i_wb_stb` in 1: Wishbone strobe.
- `o_wb_rdt` out 32: read data.
- `o_wb_ack` out 1: single-cycle acknowledge.
- `o_irq` out 1: result-available interrupt.

## Operation
Capture:
- A registered copy `valid_d` of `i_valid` is kept; a push request is `i_valid & ~valid_d`.
- Each push request stores `{i_timestep, i_data}`, sampled in the same cycle as the rising edge.
- If the FIFO is full and no pop happens in that cycle: the entry is dropped, `drop_cnt` increments (16 bits, saturates at 0xFFFF) and sticky `ovf` is set.

Register map (word address):
- 0, DATA, read-only: `{1'b1, 10'b0, ts[20:13], data[12:0]}` for the head entry; a read pops the head.
  - Read when empty returns 0 (bit31 = 0) with no pop.
  - Writes to address 0 are acked and ignored.
- 1, STATUS, read-only: bit0 `empty`, bit1 `full`, bit2 `ovf`, bits[12:8] `count` (0..`DEPTH`).
- 2, CTRL, read/write: bit0 `irq_en`.
  - Writing bit1 = 1 is a flush: pointers, `count` and `ovf` are cleared.
  - Bit1 self-clears and always reads 0.
- 3, DROP, read: `{16'b0, drop_cnt}`. Any write clears `drop_cnt`.

Simultaneous events:
- Push and pop in the same cycle while full: the pop frees a slot and the push is accepted; `count` is unchanged and no drop occurs.
- Push and pop in the same cycle while empty: the pop returns the empty value (0, no pop); the push is accepted.
- Flush and push in the same cycle: the flush wins and the new entry is discarded; it is not counted as a drop.
- Pointers are `log2(DEPTH)` bits wide and wrap naturally; `count` is a separate counter.

## Timing
- Reset values: `o_wb_rdt` = 0, `o_wb_ack` = 0, `o_irq` = 0; `valid_d`, pointers, `count`, `ovf`, `drop_cnt` and `irq_en` all 0.
- Wishbone handshake:
  - A request is `i_wb_cyc & i_wb_stb & ~o_wb_ack`.
  - `o_wb_ack` is asserted for exactly 1 cycle, on the cycle after the request.
  - `o_wb_rdt` is valid in the same cycle as `o_wb_ack`.
  - Back-to-back requests therefore complete every 2 cycles.
- Pop and register side effects (pop, flush, clear) take effect on the request cycle edge, i.e. when ack is registered.
- Capture latency: the rising edge of `i_valid` at edge N makes the entry visible as `count` / `empty` at edge N+1. `o_irq` is registered: `irq_en & ~empty`, asserted at edge N+2.
- `i_valid` held high for many cycles produces exactly one entry; it must drop low for at least 1 cycle before the next capture.
- Reset asserted mid-transaction: all state clears immediately and no ack is issued for the pending request.

## Test plan
- Reset, then one `i_valid` pulse with data 0x1ABC, timestep 5 → STATUS `count` = 1, `empty` = 0; DATA reads 0x80000000 | (5<<13) | 0x1ABC; STATUS then reads `empty` = 1.
- `i_valid` held high for 20 cycles → exactly 1 entry.
- 18 separate pulses with `DEPTH` = 16 → `full` = 1, `ovf` = 1, DROP = 2; the 16 reads return the first 16 values in order.
- FIFO full with a DATA read on the same cycle as a rising edge of `i_valid` → `count` stays 16, DROP is unchanged, and the new entry is last in read order.
- `irq_en` = 1 with one push → `o_irq` rises 2 cycles after the push edge and falls after the popping read; writing CTRL = 0x3 with 3 entries → `count` = 0, `ovf` = 0, `o_irq` = 0.
- Read DATA when empty → 0, ack in 1 cycle; assert `i_rst_n` low during a pending request → no ack, all outputs 0.
